// File: rtl/c8_pkg.sv
// Shared types and constants for the c8 load/increment sequencer.
package c8_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2
  } state_e;

  // Bit positions in the arbiter request/grant vectors match these values.
  typedef enum logic {
    SRC_B = 1'b0,
    SRC_A = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/c8_rr_arb2.sv
// Two-way round-robin arbiter. The pointer only moves on a contested grant,
// so an uncontested winner does not lose priority it never had to use.
module c8_rr_arb2
  import c8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o,
  output src_e       ptr_o
);

  src_e       ptr_q;
  src_e       ptr_d;
  logic [1:0] gnt;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (advance_i) begin
      unique case (req_i)
        2'b10:   gnt = 2'b10;
        2'b01:   gnt = 2'b01;
        2'b11: begin
          gnt   = (ptr_q == SRC_A) ? 2'b10 : 2'b01;
          ptr_d = other_src(ptr_q);
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= SRC_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt;
  assign ptr_o = ptr_q;

endmodule

// File: rtl/c8_seq_ctrl.sv
// Load/start/increment sequencer for the c8 datapath: arbitrates two load
// sources, then counts under inc_en until wrap or abort.
module c8_seq_ctrl
  import c8_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_a_req,
  input  logic [WIDTH-1:0] ld_a_val,
  input  logic             ld_b_req,
  input  logic [WIDTH-1:0] ld_b_val,
  input  logic             start,
  input  logic             inc_en,
  input  logic             abort,
  output logic             ld_a_gnt,
  output logic             ld_b_gnt,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             cout,
  output logic             dp_q,
  output logic             dp_s
);

  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic             a_gnt_q;
  logic             b_gnt_q;
  logic             done_q;
  logic             cout_q;
  logic             dp_s_q;

  logic [1:0]       arb_gnt;
  src_e             rr_ptr_unused;
  logic             arb_adv;

  // Arbitration only happens while idle; requests held into LOADED are dropped.
  assign arb_adv = (state_q == IDLE);

  c8_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     ({ld_a_req, ld_b_req}),
    .advance_i (arb_adv),
    .gnt_o     (arb_gnt),
    .ptr_o     (rr_ptr_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      dp_s_q  <= 1'b1;
    end else begin
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (arb_gnt != 2'b00) begin
            cnt_q   <= arb_gnt[SRC_A] ? ld_a_val : ld_b_val;
            dp_s_q  <= arb_gnt[SRC_A];
            a_gnt_q <= arb_gnt[SRC_A];
            b_gnt_q <= arb_gnt[SRC_B];
            state_q <= LOADED;
          end
        end
        LOADED: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (start) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          // Abort wins even over a wrap: no increment and no pulses.
          if (abort) begin
            state_q <= IDLE;
          end else if (inc_en) begin
            cnt_q <= cnt_q + WIDTH'(1);
            if (&cnt_q) begin
              done_q  <= 1'b1;
              cout_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ld_a_gnt = a_gnt_q;
  assign ld_b_gnt = b_gnt_q;
  assign cnt      = cnt_q;
  assign busy     = (state_q == LOADED) || (state_q == RUN);
  assign done     = done_q;
  assign cout     = cout_q;
  assign dp_s     = dp_s_q;
  assign dp_q     = (state_q == RUN) && inc_en && !abort;

endmodule

// File: tb/tb_c8_seq_ctrl.sv
// Directed bench for c8_seq_ctrl: expectations are queued as stimulus is
// driven and compared against the DUT outputs after each clock edge.
module tb_c8_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_a_req, ld_b_req, start, inc_en, abort;
  logic [7:0] ld_a_val, ld_b_val;
  logic       ld_a_gnt, ld_b_gnt, busy, done, cout, dp_q, dp_s;
  logic [7:0] cnt;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  c8_seq_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_a_req (ld_a_req),
    .ld_a_val (ld_a_val),
    .ld_b_req (ld_b_req),
    .ld_b_val (ld_b_val),
    .start    (start),
    .inc_en   (inc_en),
    .abort    (abort),
    .ld_a_gnt (ld_a_gnt),
    .ld_b_gnt (ld_b_gnt),
    .cnt      (cnt),
    .busy     (busy),
    .done     (done),
    .cout     (cout),
    .dp_q     (dp_q),
    .dp_s     (dp_s)
  );

  task automatic push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [7:0] obs);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic exp_state(input string t, input logic ga, input logic gb,
                           input logic [7:0] c, input logic bz, input logic dn,
                           input logic co, input logic ds, input logic dq);
    push({t, ".gnt_a"}, {7'd0, ga});
    push({t, ".gnt_b"}, {7'd0, gb});
    push({t, ".cnt"},   c);
    push({t, ".busy"},  {7'd0, bz});
    push({t, ".done"},  {7'd0, dn});
    push({t, ".cout"},  {7'd0, co});
    push({t, ".dp_s"},  {7'd0, ds});
    push({t, ".dp_q"},  {7'd0, dq});
  endtask

  task automatic cmp_state();
    pop_cmp({7'd0, ld_a_gnt});
    pop_cmp({7'd0, ld_b_gnt});
    pop_cmp(cnt);
    pop_cmp({7'd0, busy});
    pop_cmp({7'd0, done});
    pop_cmp({7'd0, cout});
    pop_cmp({7'd0, dp_s});
    pop_cmp({7'd0, dp_q});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ld_a_req = 0; ld_b_req = 0; start = 0; inc_en = 0; abort = 0;
    ld_a_val = 8'h00; ld_b_val = 8'h00;

    // Reset values
    exp_state("reset", 0, 0, 8'h00, 0, 0, 0, 1, 0); tick(); cmp_state();

    // 1: single A load, request held through grant
    rst = 0; ld_a_req = 1; ld_a_val = 8'h3C;
    exp_state("t1_gnt", 1, 0, 8'h3C, 1, 0, 0, 1, 0); tick(); cmp_state();
    exp_state("t1_hold", 0, 0, 8'h3C, 1, 0, 0, 1, 0); tick(); cmp_state();
    ld_a_req = 0; abort = 1;
    exp_state("t1_abort", 0, 0, 8'h3C, 0, 0, 0, 1, 0); tick(); cmp_state();
    abort = 0;

    // 2: round-robin from reset
    rst = 1;
    exp_state("t2_rst", 0, 0, 8'h00, 0, 0, 0, 1, 0); tick(); cmp_state();
    rst = 0; ld_a_req = 1; ld_b_req = 1; ld_a_val = 8'h10; ld_b_val = 8'h20;
    exp_state("t2_r1", 1, 0, 8'h10, 1, 0, 0, 1, 0); tick(); cmp_state();
    ld_a_req = 0; ld_b_req = 0; abort = 1;
    exp_state("t2_ab1", 0, 0, 8'h10, 0, 0, 0, 1, 0); tick(); cmp_state();
    abort = 0; ld_a_req = 1; ld_b_req = 1;
    exp_state("t2_r2", 0, 1, 8'h20, 1, 0, 0, 0, 0); tick(); cmp_state();
    ld_a_req = 0; ld_b_req = 0; abort = 1;
    exp_state("t2_ab2", 0, 0, 8'h20, 0, 0, 0, 0, 0); tick(); cmp_state();
    abort = 0; ld_a_req = 1; ld_b_req = 1;
    exp_state("t2_r3", 1, 0, 8'h10, 1, 0, 0, 1, 0); tick(); cmp_state();
    ld_a_req = 0; ld_b_req = 0; abort = 1;
    exp_state("t2_ab3", 0, 0, 8'h10, 0, 0, 0, 1, 0); tick(); cmp_state();
    // abort while idle does not block a load
    ld_b_req = 1;
    exp_state("t2_idle_abort", 0, 1, 8'h20, 1, 0, 0, 0, 0); tick(); cmp_state();
    ld_b_req = 0;
    exp_state("t2_ab4", 0, 0, 8'h20, 0, 0, 0, 0, 0); tick(); cmp_state();
    abort = 0;

    // start in IDLE is ignored
    start = 1;
    exp_state("idle_start", 0, 0, 8'h20, 0, 0, 0, 0, 0); tick(); cmp_state();
    start = 0;

    // 3: wrap from FD
    ld_a_req = 1; ld_a_val = 8'hFD;
    exp_state("t3_ld", 1, 0, 8'hFD, 1, 0, 0, 1, 0); tick(); cmp_state();
    ld_a_req = 0; start = 1;
    exp_state("t3_start", 0, 0, 8'hFD, 1, 0, 0, 1, 0); tick(); cmp_state();
    start = 0; inc_en = 1;
    exp_state("t3_fe", 0, 0, 8'hFE, 1, 0, 0, 1, 1); tick(); cmp_state();
    exp_state("t3_ff", 0, 0, 8'hFF, 1, 0, 0, 1, 1); tick(); cmp_state();
    exp_state("t3_wrap", 0, 0, 8'h00, 0, 1, 1, 1, 0); tick(); cmp_state();
    inc_en = 0;
    exp_state("t3_post", 0, 0, 8'h00, 0, 0, 0, 1, 0); tick(); cmp_state();

    // 4: inc_en pattern 1,0,0,1 from B load
    ld_b_req = 1; ld_b_val = 8'h05;
    exp_state("t4_ld", 0, 1, 8'h05, 1, 0, 0, 0, 0); tick(); cmp_state();
    ld_b_req = 0; start = 1;
    exp_state("t4_start", 0, 0, 8'h05, 1, 0, 0, 0, 0); tick(); cmp_state();
    start = 0; inc_en = 1;
    exp_state("t4_i1", 0, 0, 8'h06, 1, 0, 0, 0, 1); tick(); cmp_state();
    inc_en = 0;
    exp_state("t4_i0a", 0, 0, 8'h06, 1, 0, 0, 0, 0); tick(); cmp_state();
    exp_state("t4_i0b", 0, 0, 8'h06, 1, 0, 0, 0, 0); tick(); cmp_state();
    inc_en = 1;
    exp_state("t4_i1b", 0, 0, 8'h07, 1, 0, 0, 0, 1); tick(); cmp_state();
    inc_en = 0; abort = 1;
    exp_state("t4_ab", 0, 0, 8'h07, 0, 0, 0, 0, 0); tick(); cmp_state();
    abort = 0;

    // 5: abort beats the wrap from FF
    ld_a_req = 1; ld_a_val = 8'hFF;
    exp_state("t5_ld", 1, 0, 8'hFF, 1, 0, 0, 1, 0); tick(); cmp_state();
    ld_a_req = 0; start = 1;
    exp_state("t5_start", 0, 0, 8'hFF, 1, 0, 0, 1, 0); tick(); cmp_state();
    start = 0; abort = 1; inc_en = 1;
    push("t5_dpq_abort", 8'h00); #1; pop_cmp({7'd0, dp_q});
    exp_state("t5_ab", 0, 0, 8'hFF, 0, 0, 0, 1, 0); tick(); cmp_state();
    abort = 0; inc_en = 0;
    exp_state("t5_post", 0, 0, 8'hFF, 0, 0, 0, 1, 0); tick(); cmp_state();

    // 6: reset mid-RUN at 80, then pointer back on A (it was on B)
    ld_a_req = 1; ld_a_val = 8'h7F;
    exp_state("t6_ld", 1, 0, 8'h7F, 1, 0, 0, 1, 0); tick(); cmp_state();
    ld_a_req = 0; start = 1;
    exp_state("t6_start", 0, 0, 8'h7F, 1, 0, 0, 1, 0); tick(); cmp_state();
    start = 0; inc_en = 1;
    exp_state("t6_80", 0, 0, 8'h80, 1, 0, 0, 1, 1); tick(); cmp_state();
    rst = 1;
    exp_state("t6_rst", 0, 0, 8'h00, 0, 0, 0, 1, 0); tick(); cmp_state();
    rst = 0; inc_en = 0; ld_a_req = 1; ld_b_req = 1; ld_a_val = 8'hAA; ld_b_val = 8'hBB;
    exp_state("t6_ptrA", 1, 0, 8'hAA, 1, 0, 0, 1, 0); tick(); cmp_state();
    ld_a_req = 0; ld_b_req = 0;

    compared++;
    assert (sb.size() == 0) else begin
      mismatched++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/c8_seq_ctrl.md
Name: c8_seq_ctrl

Overview:
Sequencer and arbiter for the c8 load/increment datapath.
- Two load requesters share one count register through a 2-way round-robin arbiter.
- A small FSM loads the granted value, waits for start, then increments under inc_en until wrap or abort.
- Drives datapath controls: dp_q (increment select) and dp_s (load-source select). Exposes count, carry-out and done status.

Parameters:
WIDTH, 8, count register and load value width (the c8 datapath is 8 bits).

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  reset, synchronous, active-high
ld_a_req  in  1  load request, source A; held high until ld_a_gnt seen
ld_a_val  in  WIDTH  load value, source A
ld_b_req  in  1  load request, source B; held high until ld_b_gnt seen
ld_b_val  in  WIDTH  load value, source B
start  in  1  begin counting from the loaded value
inc_en  in  1  increment qualifier while counting
abort  in  1  return to IDLE, count retained
ld_a_gnt  out  1  one-cycle grant pulse, source A
ld_b_gnt  out  1  one-cycle grant pulse, source B
cnt  out  WIDTH  count register
busy  out  1  high in LOADED or RUN
done  out  1  one-cycle pulse on terminal wrap
cout  out  1  one-cycle carry-out pulse (all-ones to zero)
dp_q  out  1  datapath increment select, combinational: state==RUN & inc_en & ~abort
dp_s  out  1  datapath source select; 1=A, 0=B; registered, holds last grant

Behaviour:
Interface:
- One clock, clk.
- Reset rst is synchronous and active-high.

Reset values (edge with rst=1, overrides all other inputs):
- state=IDLE, cnt=0, ld_a_gnt=ld_b_gnt=0, done=0, cout=0, dp_s=1, rr_ptr=A (A preferred).
- Reset mid-RUN discards the count and emits no done.

FSM states: IDLE, LOADED, RUN.

IDLE:
- Any request at an edge: arbiter picks one source.
  - Only one requests: that one wins.
  - Both request: rr_ptr side wins; rr_ptr then moves to the other side.
- At that edge: cnt<=winner value, dp_s<=winner, winner gnt<=1 for exactly one cycle, state<=LOADED.
- Grant visible the cycle after the request is sampled (latency 1).
- Values are sampled at the granting edge only.
- Requests still high during the gnt cycle are ignored (state is no longer IDLE).
- start and inc_en are ignored in IDLE.

LOADED:
- busy=1.
- start: state<=RUN.
- Load requests are ignored.

RUN:
- busy=1.
- inc_en=1: cnt<=cnt+1, modulo 2^WIDTH.
- inc_en=0: cnt holds.
- Increment from all-ones: cnt<=0, cout<=1 and done<=1 for one cycle, state<=IDLE.
- start is ignored.

abort (LOADED or RUN):
- state<=IDLE, cnt holds, no done/cout.
- abort has priority over start, over increment, and over the simultaneous wrap (no increment, no pulse).
- abort in IDLE has no effect; a load still proceeds that cycle.

done/cout are registered and coincide with cnt==0 after the wrap.

Decomposition:
- Package c8_pkg:
  - WIDTH_DEF = 8
  - state enum {IDLE, LOADED, RUN}
  - src_e {SRC_B=0, SRC_A=1}
- Sub-module c8_rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Outputs: one-hot grant, pointer register.
  - Synchronous active-high reset.
- The FSM, count register and pulse flops stay in c8_seq_ctrl.

Test Plan:
1. Reset, then ld_a_req=1, ld_a_val=8'h3C -> next cycle ld_a_gnt=1 for one cycle, cnt=3C, dp_s=1, busy=1; request held through gnt gives no second grant.
2. Both requests together from reset (A=8'h10, B=8'h20) -> A granted, cnt=10. Abort, then both again -> B granted, cnt=20, dp_s=0. Third round -> A again.
3. Load 8'hFD, start, inc_en=1 for 3 cycles -> cnt FE, FF, 00; on the 00 cycle done=1 and cout=1, state IDLE, busy=0.
4. Load 8'h05, start, inc_en pattern 1,0,0,1 -> cnt 06,06,06,07; dp_q follows the inc_en pattern.
5. Load 8'hFF, start, then abort and inc_en together -> cnt stays FF, no done/cout, IDLE next cycle.
6. rst asserted mid-RUN at cnt=8'h80 -> next cycle cnt=00, IDLE, all pulses 0, rr_ptr=A.
